// File: rtl/pkt_pkg.sv
// Shared packet-word flag encodings, source indices and arbiter state codes
// for the three-source packet multiplexer.
package pkt_pkg;

    localparam int unsigned NumSrc = 3;

    localparam logic [1:0] FlagHead = 2'b01;
    localparam logic [1:0] FlagMid  = 2'b11;
    localparam logic [1:0] FlagTail = 2'b10;

    localparam logic [1:0] SrcPgm = 2'd0;
    localparam logic [1:0] SrcLcm = 2'd1;
    localparam logic [1:0] SrcSsm = 2'd2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDrop = 2'd2;

    function automatic logic [1:0] next_src(input logic [1:0] src);
        return (src == SrcSsm) ? SrcPgm : src + 2'd1;
    endfunction

    // First requesting source after last, wrapping; last itself has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [NumSrc-1:0] req);
        logic [1:0] s1;
        logic [1:0] s2;
        s1 = next_src(last);
        s2 = next_src(s1);
        if (req[s1]) begin
            return s1;
        end else if (req[s2]) begin
            return s2;
        end
        return last;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head word readable combinationally; reads of an
// empty FIFO are ignored and writes to a full FIFO are dropped unless a pop frees space.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      used
);

    localparam logic [AW:0]   FullCnt = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      used_q;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + AW'(1);
    endfunction

    assign empty = (used_q == '0);
    assign full  = (used_q == FullCnt);
    assign used  = used_q;
    assign dout  = mem[rd_ptr_q];

    // Pop is resolved first so a full FIFO still takes a write in the same cycle.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_wr && !do_rd) begin
                used_q <= used_q + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                used_q <= used_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Three-source packet multiplexer: buffers each source's words and keep/discard
// flags, forwards kept packets whole in round-robin order and silently drops discarded ones.
module mux_arb
    import pkt_pkg::*;
#(
    parameter int unsigned DATA_W      = 134,
    parameter int unsigned DFIFO_DEPTH = 256,
    parameter int unsigned VFIFO_DEPTH = 32,
    parameter int unsigned ALF_TH      = 160
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] pgm2mux_data,
    input  logic              pgm2mux_data_wr,
    input  logic              pgm2mux_data_valid,
    input  logic              pgm2mux_data_valid_wr,
    output logic              mux2pgm_alf,

    input  logic [DATA_W-1:0] lcm2mux_data,
    input  logic              lcm2mux_data_wr,
    input  logic              lcm2mux_data_valid,
    input  logic              lcm2mux_data_valid_wr,
    output logic              mux2lcm_alf,

    input  logic [DATA_W-1:0] ssm2mux_data,
    input  logic              ssm2mux_data_wr,
    input  logic              ssm2mux_data_valid,
    input  logic              ssm2mux_data_valid_wr,
    output logic              mux2ssm_alf,

    output logic [DATA_W-1:0] pktout_data,
    output logic              pktout_data_wr,
    output logic              pktout_data_valid,
    output logic              pktout_data_valid_wr,
    input  logic              pktout_ready,

    // Sticky per-source record of words or flags lost to a full FIFO.
    output logic [NumSrc-1:0] ovf
);

    localparam int unsigned DAW = (DFIFO_DEPTH > 1) ? $clog2(DFIFO_DEPTH) : 1;
    localparam int unsigned VAW = (VFIFO_DEPTH > 1) ? $clog2(VFIFO_DEPTH) : 1;

    logic [DATA_W-1:0] in_data [NumSrc];
    logic [NumSrc-1:0] in_wr;
    logic [NumSrc-1:0] in_valid;
    logic [NumSrc-1:0] in_vwr;

    logic [DATA_W-1:0] d_dout [NumSrc];
    logic [DAW:0]      d_used [NumSrc];
    logic [NumSrc-1:0] d_full;
    logic [NumSrc-1:0] d_empty;
    logic [NumSrc-1:0] d_rd;

    logic [VAW:0]      v_used [NumSrc];
    logic [NumSrc-1:0] v_dout;
    logic [NumSrc-1:0] v_full;
    logic [NumSrc-1:0] v_empty;
    logic [NumSrc-1:0] v_rd;

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_q, last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_wr_q, out_wr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_vwr_q, out_vwr_d;
    logic [NumSrc-1:0] alf_q, alf_d;
    logic [NumSrc-1:0] ovf_q, ovf_d;

    logic [1:0]        pick;
    logic              pick_keep;
    logic [DATA_W-1:0] cur_word;
    logic              cur_avail;
    logic              cur_tail;

    assign in_data[0] = pgm2mux_data;
    assign in_data[1] = lcm2mux_data;
    assign in_data[2] = ssm2mux_data;
    assign in_wr    = {ssm2mux_data_wr, lcm2mux_data_wr, pgm2mux_data_wr};
    assign in_valid = {ssm2mux_data_valid, lcm2mux_data_valid, pgm2mux_data_valid};
    assign in_vwr   = {ssm2mux_data_valid_wr, lcm2mux_data_valid_wr, pgm2mux_data_valid_wr};

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        sync_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (DFIFO_DEPTH)
        ) u_dfifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_wr[i]),
            .din   (in_data[i]),
            .rd    (d_rd[i]),
            .dout  (d_dout[i]),
            .full  (d_full[i]),
            .empty (d_empty[i]),
            .used  (d_used[i])
        );

        sync_fifo #(
            .WIDTH (1),
            .DEPTH (VFIFO_DEPTH)
        ) u_vfifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_vwr[i]),
            .din   (in_valid[i]),
            .rd    (v_rd[i]),
            .dout  (v_dout[i]),
            .full  (v_full[i]),
            .empty (v_empty[i]),
            .used  (v_used[i])
        );
    end

    always_comb begin
        pick      = rr_pick(last_q, ~v_empty);
        pick_keep = 1'b0;
        cur_word  = '0;
        cur_avail = 1'b0;
        for (int i = 0; i < NumSrc; i++) begin
            if (grant_q == 2'(i)) begin
                cur_word  = d_dout[i];
                cur_avail = !d_empty[i];
            end
            if (pick == 2'(i)) begin
                pick_keep = v_dout[i];
            end
        end
        cur_tail = (cur_word[DATA_W-1 -: 2] == FlagTail);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        out_data_d  = '0;
        out_wr_d    = 1'b0;
        out_valid_d = 1'b0;
        out_vwr_d   = 1'b0;
        d_rd        = '0;
        v_rd        = '0;
        unique case (state_q)
            StIdle: begin
                // Downstream readiness is only consulted here; a started packet always completes.
                if (pktout_ready && (v_empty != '1)) begin
                    grant_d = pick;
                    v_rd    = NumSrc'(1) << pick;
                    state_d = pick_keep ? StSend : StDrop;
                end
            end
            StSend: begin
                if (cur_avail) begin
                    d_rd       = NumSrc'(1) << grant_q;
                    out_data_d = cur_word;
                    out_wr_d   = 1'b1;
                    if (cur_tail) begin
                        out_valid_d = 1'b1;
                        out_vwr_d   = 1'b1;
                        last_d      = grant_q;
                        state_d     = StIdle;
                    end
                end
            end
            StDrop: begin
                if (cur_avail) begin
                    d_rd = NumSrc'(1) << grant_q;
                    if (cur_tail) begin
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q | (in_wr & d_full & ~d_rd) | (in_vwr & v_full & ~v_rd);
        alf_d = '0;
        for (int i = 0; i < NumSrc; i++) begin
            alf_d[i] = (32'(d_used[i]) >= ALF_TH) || ((32'(v_used[i]) + 32'd2) >= VFIFO_DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= SrcPgm;
            last_q      <= SrcSsm;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_vwr_q   <= 1'b0;
            alf_q       <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_wr_q    <= out_wr_d;
            out_valid_q <= out_valid_d;
            out_vwr_q   <= out_vwr_d;
            alf_q       <= alf_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pktout_data          = out_data_q;
    assign pktout_data_wr       = out_wr_q;
    assign pktout_data_valid    = out_valid_q;
    assign pktout_data_valid_wr = out_vwr_q;
    assign mux2pgm_alf          = alf_q[0];
    assign mux2lcm_alf          = alf_q[1];
    assign mux2ssm_alf          = alf_q[2];
    assign ovf                  = ovf_q;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: per-source queues of expected words filled by the
// stimulus, drained by an output monitor; directed scenarios plus a randomized phase.
module tb_mux_arb;
    import pkt_pkg::*;

    localparam int unsigned DW = 134;

    typedef struct {
        int          src;
        int unsigned head_cyc;
        int unsigned tail_cyc;
        int          len;
    } pkt_log_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pktout_ready;
    logic [DW-1:0]     s_data [3];
    logic              s_wr [3];
    logic              s_valid [3];
    logic              s_vwr [3];
    logic [2:0]        alf;
    logic [2:0]        ovf;
    logic [DW-1:0]     pktout_data;
    logic              pktout_data_wr;
    logic              pktout_data_valid;
    logic              pktout_data_valid_wr;

    int unsigned       cyc = 0;
    int                checks = 0;
    int                errors = 0;
    logic [DW-1:0]     exp_q [3][$];
    pkt_log_t          log_q [$];
    int                seq_cnt [3];
    int unsigned       last_push_cyc [3];
    int                out_words = 0;
    bit                mon_in_pkt = 0;
    int                mon_src = 0;
    int unsigned       mon_head = 0;
    int                mon_len = 0;
    bit                rand_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_arb u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .pgm2mux_data          (s_data[0]),
        .pgm2mux_data_wr       (s_wr[0]),
        .pgm2mux_data_valid    (s_valid[0]),
        .pgm2mux_data_valid_wr (s_vwr[0]),
        .mux2pgm_alf           (alf[0]),
        .lcm2mux_data          (s_data[1]),
        .lcm2mux_data_wr       (s_wr[1]),
        .lcm2mux_data_valid    (s_valid[1]),
        .lcm2mux_data_valid_wr (s_vwr[1]),
        .mux2lcm_alf           (alf[1]),
        .ssm2mux_data          (s_data[2]),
        .ssm2mux_data_wr       (s_wr[2]),
        .ssm2mux_data_valid    (s_valid[2]),
        .ssm2mux_data_valid_wr (s_vwr[2]),
        .mux2ssm_alf           (alf[2]),
        .pktout_data           (pktout_data),
        .pktout_data_wr        (pktout_data_wr),
        .pktout_data_valid     (pktout_data_valid),
        .pktout_data_valid_wr  (pktout_data_valid_wr),
        .pktout_ready          (pktout_ready),
        .ovf                   (ovf)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event, expected one (cycle %0d)", name, cyc);
    endtask

    // Word layout: flag, source id, packet sequence, word index, random filler.
    function automatic logic [DW-1:0] mk_word(input int src, input int seq, input int idx,
                                              input logic [1:0] flag);
        logic [DW-1:0] w = '0;
        w[133:132] = flag;
        w[129:128] = src[1:0];
        w[127:96]  = seq;
        w[95:64]   = idx;
        w[63:32]   = $urandom;
        w[31:0]    = $urandom;
        return w;
    endfunction

    task automatic drive(input int src, input logic [DW-1:0] w, input logic wr,
                         input logic vwr, input logic vld);
        @(posedge clk);
        #1;
        s_data[src]  = w;
        s_wr[src]    = wr;
        s_vwr[src]   = vwr;
        s_valid[src] = vld;
    endtask

    task automatic send_pkt(input int src, input int len, input bit keep);
        logic [DW-1:0] words [$];
        logic [DW-1:0] w;
        logic [1:0]    flag;
        int            seq;
        seq = seq_cnt[src];
        seq_cnt[src] = seq + 1;
        for (int i = 0; i < len; i++) begin
            flag = (i == len - 1) ? FlagTail : ((i == 0) ? FlagHead : FlagMid);
            w = mk_word(src, seq, i, flag);
            words.push_back(w);
            drive(src, w, 1'b1, (i == len - 1), (i == len - 1) && keep);
        end
        drive(src, '0, 1'b0, 1'b0, 1'b0);
        last_push_cyc[src] = cyc;
        if (keep) begin
            foreach (words[i]) exp_q[src].push_back(words[i]);
        end
    endtask

    task automatic wait_pkts(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (log_q.size() < n) timeout(name);
    endtask

    task automatic src_loop(input int src);
        int k;
        repeat (20) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            k = 0;
            while (alf[src] && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (alf[src]) timeout("rand_alf_release");
            send_pkt(src, $urandom_range(2, 10), $urandom_range(0, 4) != 0);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e;
        int            s;
        bit            is_tail;
        pkt_log_t      p;
        if (rst) begin
            mon_in_pkt = 0;
        end else if (pktout_data_wr) begin
            s = int'(pktout_data[129:128]);
            if (!mon_in_pkt) begin
                mon_in_pkt = 1;
                mon_src    = s;
                mon_head   = cyc;
                mon_len    = 0;
            end
            chk("word_source", s, mon_src);
            if (s < 3 && exp_q[s].size() > 0) begin
                e = exp_q[s].pop_front();
                chk("word_data", pktout_data, e);
            end else begin
                chk("unexpected_word", pktout_data, '0);
            end
            mon_len++;
            out_words++;
            is_tail = (pktout_data[133:132] == FlagTail);
            chk("tail_valid", pktout_data_valid, is_tail);
            chk("tail_valid_wr", pktout_data_valid_wr, is_tail);
            if (is_tail) begin
                p.src      = mon_src;
                p.head_cyc = mon_head;
                p.tail_cyc = cyc;
                p.len      = mon_len;
                log_q.push_back(p);
                mon_in_pkt = 0;
            end
        end else begin
            chk("idle_data", pktout_data, '0);
            chk("idle_valid", pktout_data_valid, 1'b0);
            chk("idle_valid_wr", pktout_data_valid_wr, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        int k;
        logic [DW-1:0] w;
        logic [1:0]    flag;

        pktout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data[i] = '0; s_wr[i] = 0; s_valid[i] = 0; s_vwr[i] = 0;
            seq_cnt[i] = 0; last_push_cyc[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_data", pktout_data, '0);
        chk("reset_wr", pktout_data_wr, 1'b0);
        chk("reset_valid", pktout_data_valid, 1'b0);
        chk("reset_valid_wr", pktout_data_valid_wr, 1'b0);
        chk("reset_alf", alf, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        pktout_ready = 1'b1;

        // Simultaneous packets from reset: round-robin starts after ssm.
        n = log_q.size();
        fork
            send_pkt(0, 4, 1);
            send_pkt(1, 4, 1);
            send_pkt(2, 4, 1);
        join
        wait_pkts(n + 3, 200, "rr_three_packets");
        if (log_q.size() >= n + 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("rr_order", log_q[n + j].src, (2 + 1 + j) % 3);
                chk("rr_len", log_q[n + j].len, 4);
            end
            chk("rr_gap_1", log_q[n + 1].head_cyc, log_q[n].tail_cyc + 2);
            chk("rr_gap_2", log_q[n + 2].head_cyc, log_q[n + 1].tail_cyc + 2);
        end

        // Single 6-word packet and its latency from the keep-flag push.
        n = log_q.size();
        send_pkt(0, 6, 1);
        wait_pkts(n + 1, 100, "single_packet");
        if (log_q.size() >= n + 1) begin
            chk("single_src", log_q[n].src, 0);
            chk("single_len", log_q[n].len, 6);
            chk("single_latency", log_q[n].head_cyc, last_push_cyc[0] + 2);
        end

        // Discarded packet followed by a kept one.
        n = log_q.size();
        send_pkt(1, 7, 0);
        send_pkt(1, 3, 1);
        wait_pkts(n + 1, 200, "drop_then_keep");
        repeat (20) @(negedge clk);
        chk("drop_pkt_count", log_q.size(), n + 1);
        if (log_q.size() >= n + 1) begin
            chk("drop_kept_src", log_q[n].src, 1);
            chk("drop_kept_len", log_q[n].len, 3);
        end

        // Readiness gating, then readiness dropping mid-packet.
        pktout_ready = 1'b0;
        n = log_q.size();
        base = out_words;
        send_pkt(2, 5, 1);
        repeat (20) @(negedge clk);
        chk("not_ready_no_output", out_words, base);
        @(posedge clk);
        #1 pktout_ready = 1'b1;
        k = 0;
        while (out_words == base && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (out_words == base) timeout("ready_rise_output");
        pktout_ready = 1'b0;
        wait_pkts(n + 1, 50, "ready_drop_complete");
        if (log_q.size() >= n + 1) begin
            chk("ready_drop_src", log_q[n].src, 2);
            chk("ready_drop_len", log_q[n].len, 5);
        end
        pktout_ready = 1'b1;

        // Almost-full threshold on pgm data FIFO, then drain by discarding.
        base = out_words;
        for (int i = 0; i < 159; i++) begin
            flag = (i == 0) ? FlagHead : FlagMid;
            w = mk_word(0, 999, i, flag);
            drive(0, w, 1'b1, 1'b0, 1'b0);
        end
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("alf_at_159", alf[0], 1'b0);
        w = mk_word(0, 999, 159, FlagTail);
        drive(0, w, 1'b1, 1'b0, 1'b0);
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("alf_at_160", alf[0], 1'b1);
        chk("alf_other_src", alf[2:1], 2'b00);
        drive(0, '0, 1'b0, 1'b1, 1'b0);
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (alf[0] && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("alf_after_drain", alf[0], 1'b0);
        repeat (200) @(negedge clk);
        chk("drain_no_output", out_words, base);

        // Reset while the third word of an 8-word packet is on the output.
        base = out_words;
        send_pkt(0, 8, 1);
        k = 0;
        while (out_words < base + 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (out_words < base + 3) timeout("reset_third_word");
        #2 rst = 1'b1;
        #1;
        chk("rst_now_data", pktout_data, '0);
        chk("rst_now_wr", pktout_data_wr, 1'b0);
        chk("rst_now_valid", {pktout_data_valid, pktout_data_valid_wr}, 2'b00);
        chk("rst_now_alf", alf, 3'b000);
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = out_words;
        repeat (20) @(negedge clk);
        chk("rst_no_stray", out_words, base);
        n = log_q.size();
        send_pkt(0, 8, 1);
        wait_pkts(n + 1, 100, "after_reset_packet");
        if (log_q.size() >= n + 1) begin
            chk("after_reset_src", log_q[n].src, 0);
            chk("after_reset_len", log_q[n].len, 8);
        end

        // Randomized traffic with random downstream readiness.
        fork
            begin
                fork
                    src_loop(0);
                    src_loop(1);
                    src_loop(2);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 pktout_ready = ($urandom_range(0, 9) < 7);
                end
                pktout_ready = 1'b1;
            end
        join
        k = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || mon_in_pkt)
               && k < 3000) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 3; i++) chk("rand_drained", exp_q[i].size(), 0);
        chk("ovf_clear", ovf, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
